// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state type, frame constants and baud divisor helper
// UART_PARITY_EN adds the PARITY state used by 8E1 framing.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned MID_SAMPLE = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_PARITY_EN
    PARITY,
`endif
    STOP
  } uart_state_e;

  function automatic int unsigned calc_div(input int unsigned f, input int unsigned b);
    int unsigned d;
    d = f / (OVERSAMPLE * b);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - oversample tick generator, one tick every DIV clocks
// restart_i zeroes the phase so a new TX frame starts on a full tick period.
module uart_baud_gen #(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic restart_i,
  output logic tick_o
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = tick_o ? '0 : cnt_q + CW'(1);
    if (restart_i) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_transceiver.sv
// rtl/uart_transceiver.sv - full-duplex 8N1 UART with byte handshake
// Define UART_PARITY_EN for 8E1 framing (even parity between D7 and stop).
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int unsigned freq_hz = 100000000,
  parameter int unsigned baud    = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rxd,
  output logic       uart_txd,
  output logic [7:0] rx_data,
  output logic       rx_avail,
  output logic       rx_error,
  input  logic       rx_ack,
  input  logic [7:0] tx_data,
  input  logic       tx_wr,
  output logic       tx_busy
);

  localparam int unsigned DIV      = calc_div(freq_hz, baud);
  localparam logic [3:0]  OS_LAST  = 4'(OVERSAMPLE - 1);
  localparam logic [3:0]  OS_MID   = 4'(MID_SAMPLE - 1);
  localparam logic [2:0]  BIT_LAST = 3'(DATA_BITS - 1);

  uart_state_e tx_state_q, tx_state_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic [3:0]  tx_os_q, tx_os_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic        tx_restart, tx_tick, tx_bit_done;
`ifdef UART_PARITY_EN
  logic        tx_par_q, tx_par_d;
`endif

  uart_baud_gen #(.DIV(DIV)) u_tx_baud (
    .clk       (clk),
    .reset     (reset),
    .restart_i (tx_restart),
    .tick_o    (tx_tick)
  );

  assign tx_bit_done = tx_tick && (tx_os_q == OS_LAST);
  assign tx_busy     = (tx_state_q != IDLE);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_os_d    = tx_os_q;
    tx_bit_d   = tx_bit_q;
    tx_restart = 1'b0;
`ifdef UART_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    // 4-bit tick count wraps at 16, marking each bit boundary
    if (tx_state_q != IDLE && tx_tick) tx_os_d = tx_os_q + 4'd1;
    case (tx_state_q)
      IDLE: begin
        if (tx_wr) begin
          tx_shift_d = tx_data;
          tx_os_d    = '0;
          tx_bit_d   = '0;
          tx_restart = 1'b1;
          tx_state_d = START;
`ifdef UART_PARITY_EN
          tx_par_d   = ^tx_data;
`endif
        end
      end
      START: if (tx_bit_done) tx_state_d = DATA;
      DATA: begin
        if (tx_bit_done) begin
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_bit_d   = tx_bit_q + 3'd1;
          if (tx_bit_q == BIT_LAST) begin
`ifdef UART_PARITY_EN
            tx_state_d = PARITY;
`else
            tx_state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      PARITY: if (tx_bit_done) tx_state_d = STOP;
`endif
      STOP: if (tx_bit_done) tx_state_d = IDLE;
      default: tx_state_d = IDLE;
    endcase
  end

  always_comb begin
    uart_txd = 1'b1;
    case (tx_state_q)
      START:   uart_txd = 1'b0;
      DATA:    uart_txd = tx_shift_q[0];
`ifdef UART_PARITY_EN
      PARITY:  uart_txd = tx_par_q;
`endif
      default: uart_txd = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q <= IDLE;
      tx_shift_q <= '0;
      tx_os_q    <= '0;
      tx_bit_q   <= '0;
`ifdef UART_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else begin
      tx_state_q <= tx_state_d;
      tx_shift_q <= tx_shift_d;
      tx_os_q    <= tx_os_d;
      tx_bit_q   <= tx_bit_d;
`ifdef UART_PARITY_EN
      tx_par_q   <= tx_par_d;
`endif
    end
  end

  uart_state_e rx_state_q, rx_state_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic [3:0]  rx_os_q, rx_os_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic        rx_avail_q, rx_avail_d;
  logic        rx_error_q, rx_error_d;
  logic        rxd_meta_q, rxd_sync_q, rxd_prev_q;
  logic        rx_tick, rx_mid, rx_full;
  logic        rx_perr;
`ifdef UART_PARITY_EN
  logic        rx_perr_q, rx_perr_d;
  assign rx_perr = rx_perr_q;
`else
  assign rx_perr = 1'b0;
`endif

  uart_baud_gen #(.DIV(DIV)) u_rx_baud (
    .clk       (clk),
    .reset     (reset),
    .restart_i (1'b0),
    .tick_o    (rx_tick)
  );

  assign rx_mid   = rx_tick && (rx_os_q == OS_MID);
  assign rx_full  = rx_tick && (rx_os_q == OS_LAST);
  assign rx_data  = rx_data_q;
  assign rx_avail = rx_avail_q;
  assign rx_error = rx_error_q;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_os_d    = rx_os_q;
    rx_bit_d   = rx_bit_q;
    rx_avail_d = rx_avail_q;
    rx_error_d = rx_error_q;
`ifdef UART_PARITY_EN
    rx_perr_d  = rx_perr_q;
`endif
    // ack is applied first so a coinciding frame completion overrides it
    if (rx_ack) begin
      rx_avail_d = 1'b0;
      rx_error_d = 1'b0;
    end
    if (rx_state_q != IDLE && rx_tick) rx_os_d = rx_os_q + 4'd1;
    case (rx_state_q)
      IDLE: begin
        if (rxd_prev_q && !rxd_sync_q) begin
          rx_os_d    = '0;
          rx_state_d = START;
        end
      end
      START: begin
        if (rx_mid) begin
          if (rxd_sync_q) begin
            rx_state_d = IDLE;
          end else begin
            rx_os_d    = '0;
            rx_bit_d   = '0;
            rx_state_d = DATA;
          end
        end
      end
      DATA: begin
        if (rx_full) begin
          rx_shift_d = {rxd_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == BIT_LAST) begin
`ifdef UART_PARITY_EN
            rx_state_d = PARITY;
`else
            rx_state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        if (rx_full) begin
          rx_perr_d  = rxd_sync_q ^ (^rx_shift_q);
          rx_state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (rx_full) begin
          if (rxd_sync_q && !rx_perr) begin
            rx_data_d  = rx_shift_q;
            rx_avail_d = 1'b1;
          end else begin
            rx_error_d = 1'b1;
          end
          rx_state_d = IDLE;
        end
      end
      default: rx_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
      rx_state_q <= IDLE;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_os_q    <= '0;
      rx_bit_q   <= '0;
      rx_avail_q <= 1'b0;
      rx_error_q <= 1'b0;
`ifdef UART_PARITY_EN
      rx_perr_q  <= 1'b0;
`endif
    end else begin
      rxd_meta_q <= uart_rxd;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
      rx_state_q <= rx_state_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_os_q    <= rx_os_d;
      rx_bit_q   <= rx_bit_d;
      rx_avail_q <= rx_avail_d;
      rx_error_q <= rx_error_d;
`ifdef UART_PARITY_EN
      rx_perr_q  <= rx_perr_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_transceiver.sv
// tb/tb_uart_transceiver.sv - directed scoreboard bench for uart_transceiver (8N1 build)
module tb_uart_transceiver;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       drv_rxd = 1'b1;
  logic       loop_en = 1'b0;
  logic       rxd_line;
  logic       uart_txd;
  logic [7:0] rx_data;
  logic       rx_avail;
  logic       rx_error;
  logic       rx_ack = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_wr = 1'b0;
  logic       tx_busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;

  always #10 clk = ~clk;

  assign rxd_line = loop_en ? uart_txd : drv_rxd;

  uart_transceiver #(.freq_hz(50000000), .baud(1152000)) dut (
    .clk      (clk),
    .reset    (reset),
    .uart_rxd (rxd_line),
    .uart_txd (uart_txd),
    .rx_data  (rx_data),
    .rx_avail (rx_avail),
    .rx_error (rx_error),
    .rx_ack   (rx_ack),
    .tx_data  (tx_data),
    .tx_wr    (tx_wr),
    .tx_busy  (tx_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_tx(input logic [7:0] b);
    @(negedge clk);
    tx_data = b;
    tx_wr   = 1'b1;
    @(negedge clk);
    tx_wr   = 1'b0;
  endtask

  task automatic tx_frame_check(input logic [7:0] b, input bit inject);
    logic [9:0] line;
    int busy_cycles;
    line = {1'b1, b, 1'b0};
    busy_cycles = 0;
    send_tx(b);
    for (int i = 0; i < 400; i++) begin
      if (tx_busy) busy_cycles++;
      if ((i % 32) == 16 && i < 320)
        check($sformatf("txd_%0h_bit%0d", b, i / 32), uart_txd, line[i / 32]);
      if (inject && i == 100) begin
        tx_data = 8'h55;
        tx_wr   = 1'b1;
      end
      if (inject && i == 101) tx_wr = 1'b0;
      @(negedge clk);
    end
    check("tx_busy_cycles", busy_cycles, 320);
    check("tx_busy_end", tx_busy, 1'b0);
  endtask

  task automatic wait_avail();
    for (int i = 0; i < 1000 && !rx_avail; i++) @(negedge clk);
    check("rx_avail_wait", rx_avail, 1'b1);
  endtask

  task automatic wait_tx_idle();
    for (int i = 0; i < 1000 && tx_busy; i++) @(negedge clk);
    check("tx_idle_wait", tx_busy, 1'b0);
  endtask

  task automatic ack_and_check();
    @(negedge clk);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    check("ack_avail", rx_avail, 1'b0);
    check("ack_error", rx_error, 1'b0);
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      drv_rxd = bits[k];
      repeat (32) @(negedge clk);
    end
    drv_rxd = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    // reset held for 80 ns
    repeat (4) @(negedge clk);
    check("rst_txd", uart_txd, 1'b1);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_avail", rx_avail, 1'b0);
    check("rst_error", rx_error, 1'b0);
    check("rst_data", rx_data, 8'h00);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    tx_frame_check(8'hA5, 1'b0);
    tx_frame_check(8'hA5, 1'b1);
    check("rx_quiet_during_tx", rx_avail, 1'b0);

    loop_en = 1'b1;
    repeat (4) @(negedge clk);
    foreach (exp_q[i]) ;
    for (int n = 0; n < 3; n++) begin
      logic [7:0] b;
      b = (n == 0) ? 8'h00 : (n == 1) ? 8'hFF : 8'h80;
      exp_q.push_back(b);
      send_tx(b);
      wait_avail();
      exp_b = exp_q.pop_front();
      check($sformatf("loop_data_%0h", exp_b), rx_data, exp_b);
      check("loop_error", rx_error, 1'b0);
      ack_and_check();
      wait_tx_idle();
    end
    loop_en = 1'b0;
    repeat (40) @(negedge clk);

    drive_frame(8'h3C, 1'b0);
    check("frame_error", rx_error, 1'b1);
    check("frame_avail", rx_avail, 1'b0);
    check("frame_data_kept", rx_data, 8'h80);
    ack_and_check();

    @(negedge clk);
    drv_rxd = 1'b0;
    repeat (10) @(negedge clk);
    drv_rxd = 1'b1;
    repeat (100) @(negedge clk);
    check("glitch_avail", rx_avail, 1'b0);
    check("glitch_error", rx_error, 1'b0);
    check("glitch_data", rx_data, 8'h80);

    exp_q.push_back(8'h11);
    drive_frame(8'h11, 1'b1);
    exp_b = exp_q.pop_front();
    check("ovr_first_data", rx_data, exp_b);
    check("ovr_first_avail", rx_avail, 1'b1);
    exp_q.push_back(8'h22);
    drive_frame(8'h22, 1'b1);
    exp_b = exp_q.pop_front();
    check("ovr_second_data", rx_data, exp_b);
    check("ovr_second_avail", rx_avail, 1'b1);
    check("ovr_second_error", rx_error, 1'b0);
    ack_and_check();
    check("scoreboard_empty", exp_q.size(), 0);

    send_tx(8'h0F);
    repeat (50) @(negedge clk);
    check("midframe_busy", tx_busy, 1'b1);
    reset = 1'b1;
    #1;
    check("midreset_txd", uart_txd, 1'b1);
    check("midreset_busy", tx_busy, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("post_reset_txd", uart_txd, 1'b1);
    check("post_reset_busy", tx_busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
